countdown_ctrl: RTL and testbench
=================================

// Module: countdown_ctrl
// PURPOSE
//  Run/pause/clear sequencer for the six-digit countdown datapath (min, seg2, seg1, deci, centi, milli).
//  - Divides the system clock into a 1 kHz digit-step strobe and owns the datapath enable and reset.
//  - Detects expiry from the digit values fed back to it.
//  - Blinks the display after expiry.
//  Sits between the button front-end (already synchronised) and the countdown datapath/display mux.
// PARAMETERS
//  CLK_HZ       50_000_000  system clock frequency
//  TICK_HZ      1000        step rate; DIV = CLK_HZ/TICK_HZ, and DIV must be >= 2
//  BLINK_TICKS  500         ticks per blink half-period in EXPIRED
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-high reset
//  btn_start  in   1  start/pause button level, synchronised; rising edge is used
//  btn_clear  in   1  clear button level, synchronised; rising edge is used
//  min_in     in   4  datapath minutes digit
//  seg2_in    in   4  datapath tens-of-seconds digit
//  seg1_in    in   4  datapath seconds digit
//  deci_in    in   4  datapath 1/10 s digit
//  centi_in   in   4  datapath 1/100 s digit
//  milli_in   in   4  datapath 1/1000 s digit
//  cd_enable  out  1  one-cycle step strobe to the datapath enable
//  cd_reset   out  1  datapath reset (reload preset)
//  blank      out  1  display blanking for blink
//  state      out  2  IDLE=0, RUN=1, PAUSE=2, EXPIRED=3
// BEHAVIOUR
//  Reset:
//  - state=IDLE, cd_enable=0, cd_reset=1, blank=0.
//  - Prescaler, blink counter, blink phase and edge registers all cleared.
//  - cd_reset falls in the first cycle after reset is released.
//  Edge detection:
//  - start_p and clear_p are 1-cycle pulses on 0->1 of the registered button level.
//  - Held buttons never repeat.
//  Expiry: expire = (all six digits == 0) | (min_in==4'hA & seg2_in==4'hB), i.e. the datapath's F-U code.
//  FSM, evaluated each cycle with priority clear_p > expire > start_p:
//  - IDLE:    start_p -> RUN (prescaler cleared to 0).
//  - RUN:     expire -> EXPIRED; start_p -> PAUSE.
//  - PAUSE:   start_p -> RUN; prescaler holds its count, so the partial period is preserved.
//  - EXPIRED: start_p ignored; only clear leaves.
//  - clear_p in any state -> IDLE, with cd_reset=1 for exactly one cycle (the cycle after clear_p) and blank=0.
//  Prescaler:
//  - 0..DIV-1; increments only in RUN and EXPIRED; wraps to 0 after DIV-1.
//  - tick = (count == DIV-1).
//  - Width is $clog2(DIV).
//  cd_enable:
//  - Registered; high in the cycle after a tick in which state==RUN and !expire.
//  - Never high in any other state.
//  - Entering RUN at cycle 0 (count=0) gives the first strobe at cycle DIV, then one every DIV cycles.
//  EXPIRED blink:
//  - On entry, blink counter=0 and blank=0.
//  - Every BLINK_TICKS ticks, blank toggles.
//  - blank=0 in all other states.
//  Reset mid-operation overrides everything, with the same values as power-up reset.
// STRUCTURE
//  Package countdown_pkg:
//  - state encodings IDLE/RUN/PAUSE/EXPIRED.
//  - digit codes CODE_F=4'hA, CODE_U=4'hB, CODE_C=4'hC.
//  Sub-module tick_prescaler (clk, reset, run, clr -> tick), parameterised by DIV.
//  FSM, edge detect and blink logic live in countdown_ctrl.
// TESTING (CLK_HZ=10, TICK_HZ=1 -> DIV=10; BLINK_TICKS=2; digits held at 0:10.000 unless stated)
//  1. reset held 3 cycles -> state=0, cd_reset=1 while held and 0 on the first cycle after release; cd_enable=0, blank=0.
//  2. start edge, RUN entered at cycle 0 -> cd_enable high at cycles 10, 20, 30 only, one cycle each.
//  3. RUN 4 cycles, then start edge -> PAUSE; hold 50 cycles with no strobe; start edge -> first strobe 6 cycles after re-entering RUN.
//  4. In RUN, drive all digits to 0 -> state=3 next cycle, no further cd_enable; blank toggles every 20 cycles.
//  5. In RUN, start and clear edges in the same cycle -> state=0 and cd_reset=1 for exactly one cycle.
//  6. In RUN, drive min_in=A, seg2_in=B -> EXPIRED; a start edge there is ignored; a clear edge -> IDLE with blank=0.

Source files
------------

// File: rtl/countdown_pkg.sv
// countdown_pkg: state encodings, digit codes and expiry test shared by the countdown controller
package countdown_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, EXPIRED = 2'd3} state_t;
    localparam logic [3:0] CODE_F = 4'hA;
    localparam logic [3:0] CODE_U = 4'hB;
    localparam logic [3:0] CODE_C = 4'hC;
    // The datapath shows F-U once it has run out, so that code counts as expired too.
    function automatic logic is_expired(input logic [3:0] m, s2, s1, d, c, ms);
        return ({m, s2, s1, d, c, ms} == 24'h0) || (m == CODE_F && s2 == CODE_U);
    endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: one-cycle tick every DIV clocks while run is high; holds its count otherwise
module tick_prescaler #(
    parameter int DIV = 50_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(DIV);
    logic [W-1:0] count;
    assign tick = count == W'(DIV - 1);
    always_ff @(posedge clk) begin
        if (reset || clr) count <= '0;
        else if (run) count <= tick ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: run/pause/clear sequencer, step strobe, expiry detect and blink for the countdown datapath
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int BLINK_TICKS = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic [3:0] min_in,
    input  logic [3:0] seg2_in,
    input  logic [3:0] seg1_in,
    input  logic [3:0] deci_in,
    input  logic [3:0] centi_in,
    input  logic [3:0] milli_in,
    output logic       cd_enable,
    output logic       cd_reset,
    output logic       blank,
    output logic [1:0] state
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int BW  = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
    state_t        st;
    logic          start_q, clear_q, start_p, clear_p, expire, tick, blink_last;
    logic [BW-1:0] blink_cnt;
    assign state      = st;
    assign start_p    = btn_start & ~start_q;
    assign clear_p    = btn_clear & ~clear_q;
    assign expire     = is_expired(min_in, seg2_in, seg1_in, deci_in, centi_in, milli_in);
    assign blink_last = blink_cnt == BW'(BLINK_TICKS - 1);
    // Held at zero in IDLE so a fresh run always starts a full period; PAUSE keeps the partial count.
    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .run  (st == RUN || st == EXPIRED),
        .clr  (st == IDLE),
        .tick (tick)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= IDLE;
            start_q   <= 1'b0;
            clear_q   <= 1'b0;
            cd_enable <= 1'b0;
            cd_reset  <= 1'b1;
            blank     <= 1'b0;
            blink_cnt <= '0;
        end else begin
            start_q   <= btn_start;
            clear_q   <= btn_clear;
            cd_reset  <= clear_p;
            cd_enable <= tick && st == RUN && !expire;
            st <= clear_p                                      ? IDLE    :
                  (st == RUN && expire)                        ? EXPIRED :
                  (start_p && (st == IDLE || st == PAUSE))     ? RUN     :
                  (start_p && st == RUN)                       ? PAUSE   : st;
            // Blink state stays zeroed outside EXPIRED, so entry always starts unblanked.
            blank     <= st == EXPIRED && !clear_p && (blank ^ (tick && blink_last));
            blink_cnt <= (st != EXPIRED || clear_p) ? '0 :
                         tick ? (blink_last ? '0 : blink_cnt + 1'b1) : blink_cnt;
        end
    end
endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: directed checks of reset, strobe timing, pause, expiry blink and clear
module tb_countdown_ctrl;
    import countdown_pkg::*;
    logic       clk = 1'b0, reset = 1'b1, btn_start = 1'b0, btn_clear = 1'b0;
    logic [3:0] min_in = 4'd0, seg2_in = 4'd1, seg1_in = 4'd0, deci_in = 4'd0, centi_in = 4'd0, milli_in = 4'd0;
    logic       cd_enable, cd_reset, blank;
    logic [1:0] state;
    int         checks = 0, errors = 0;
    always #5 clk = ~clk;
    countdown_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .BLINK_TICKS(2)) dut (
        .clk(clk), .reset(reset), .btn_start(btn_start), .btn_clear(btn_clear),
        .min_in(min_in), .seg2_in(seg2_in), .seg1_in(seg1_in),
        .deci_in(deci_in), .centi_in(centi_in), .milli_in(milli_in),
        .cd_enable(cd_enable), .cd_reset(cd_reset), .blank(blank), .state(state)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic set_digits(input logic [3:0] m, s2, s1, d, c, ms);
        {min_in, seg2_in, seg1_in, deci_in, centi_in, milli_in} = {m, s2, s1, d, c, ms};
    endtask
    initial begin
        logic seen;
        logic prev;
        int   tq[$];
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_state", state, 0);
            chk("rst_cd_reset", cd_reset, 1);
            chk("rst_cd_enable", cd_enable, 0);
            chk("rst_blank", blank, 0);
        end
        reset = 1'b0;
        step();
        chk("rel_cd_reset", cd_reset, 0);
        chk("rel_state", state, 0);
        // Start held high: strobes at RUN cycles 10, 20, 30 and no repeat of the edge
        btn_start = 1'b1;
        step();
        chk("run_enter", state, RUN);
        for (int r = 1; r <= 35; r++) begin
            step();
            chk("strobe", cd_enable, 32'(r % 10 == 0));
        end
        chk("held_no_repeat", state, RUN);
        btn_start = 1'b0;
        btn_clear = 1'b1;
        step();
        chk("clr_state", state, IDLE);
        chk("clr_cd_reset", cd_reset, 1);
        btn_clear = 1'b0;
        step();
        chk("clr_cd_reset_drop", cd_reset, 0);
        // Pause after 4 RUN cycles keeps count 4, so the resume strobe lands 6 cycles in
        btn_start = 1'b1;
        step();
        chk("run2_enter", state, RUN);
        btn_start = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            step();
            chk("run2_nostrobe", cd_enable, 0);
        end
        btn_start = 1'b1;
        step();
        chk("pause_enter", state, PAUSE);
        btn_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            seen |= cd_enable;
        end
        chk("pause_nostrobe", seen, 0);
        chk("pause_hold", state, PAUSE);
        btn_start = 1'b1;
        step();
        chk("resume", state, RUN);
        btn_start = 1'b0;
        for (int r = 1; r <= 7; r++) begin
            step();
            chk("resume_strobe", cd_enable, 32'(r == 6));
        end
        // Zero digits: prescaler enters EXPIRED at count 2, blank toggles at E18, E38, E58
        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        step();
        chk("zero_expire", state, EXPIRED);
        chk("expire_blank0", blank, 0);
        seen = 1'b0;
        prev = blank;
        for (int e = 1; e <= 60; e++) begin
            step();
            seen |= cd_enable;
            if (blank !== prev) tq.push_back(e);
            prev = blank;
        end
        chk("expired_nostrobe", seen, 0);
        chk("toggle_count", tq.size(), 3);
        chk("toggle1", (tq.size() > 0) ? tq[0] : -1, 18);
        chk("toggle2", (tq.size() > 1) ? tq[1] : -1, 38);
        chk("toggle3", (tq.size() > 2) ? tq[2] : -1, 58);
        btn_clear = 1'b1;
        step();
        chk("exp_clr_state", state, IDLE);
        chk("exp_clr_blank", blank, 0);
        btn_clear = 1'b0;
        set_digits(4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0);
        step();
        // Start and clear together: clear wins
        btn_start = 1'b1;
        step();
        chk("run3_enter", state, RUN);
        btn_start = 1'b0;
        step();
        btn_start = 1'b1;
        btn_clear = 1'b1;
        step();
        chk("both_state", state, IDLE);
        chk("both_cd_reset", cd_reset, 1);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        step();
        chk("both_cd_reset_once", cd_reset, 0);
        chk("both_idle", state, IDLE);
        // F-U code expires; start ignored; clear returns to IDLE
        btn_start = 1'b1;
        step();
        chk("run4_enter", state, RUN);
        btn_start = 1'b0;
        set_digits(CODE_F, CODE_U, 4'd0, 4'd0, 4'd0, 4'd0);
        step();
        chk("fu_expire", state, EXPIRED);
        btn_start = 1'b1;
        step();
        chk("fu_start_ignored", state, EXPIRED);
        btn_start = 1'b0;
        step();
        btn_clear = 1'b1;
        step();
        chk("fu_clr_state", state, IDLE);
        chk("fu_clr_blank", blank, 0);
        chk("fu_clr_cd_reset", cd_reset, 1);
        btn_clear = 1'b0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
